// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory responder.
// Entry layout and widths are derived from the default geometry.
package dmem_pkg;

  localparam int MEM_WORDS_DEF  = 256;
  localparam int WBUF_DEPTH_DEF = 4;
  localparam int IDX_W          = $clog2(MEM_WORDS_DEF);
  localparam int PTR_W          = $clog2(WBUF_DEPTH_DEF);
  localparam int CNT_W          = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } wbuf_entry_t;

  localparam MSG_RW_BOTH = "dmem_responder: memread and memwrite asserted in the same cycle";

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage memory port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic             memread;
  logic             memwrite;
  logic [31:0]      addr;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             stall;
  logic [CNT_W-1:0] wbuf_count;
  logic             wbuf_empty;

  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, stall, wbuf_count, wbuf_empty
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, stall, wbuf_count, wbuf_empty
  );

endinterface

// File: rtl/dmem_wbuf_fifo.sv
// Circular store buffer with a combinational youngest-match lookup for load forwarding.
module dmem_wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wbuf_entry_t      push_entry,
  input  logic             pop,
  output wbuf_entry_t      head_entry,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_hit,
  output logic [31:0]      lk_data
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] scan_ptr;
  wbuf_entry_t   ent_q [DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_q[tail_q] <= push_entry;
  end

  // Walk oldest to youngest so a younger match overrides an older one.
  always_comb begin
    lk_hit   = 1'b0;
    lk_data  = '0;
    scan_ptr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_ptr = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (ent_q[scan_ptr].idx == lk_idx)) begin
        lk_hit  = 1'b1;
        lk_data = ent_q[scan_ptr].data;
      end
    end
  end

  assign head_entry = ent_q[head_q];
  assign count      = count_q;
  assign full       = (count_q == (PW+1)'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posted stores via a write buffer, same-cycle loads with forwarding,
// buffer drains into the word array on load-free cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS  = MEM_WORDS_DEF,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int PW = $clog2(WBUF_DEPTH);

  logic [31:0]      array_q [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             push, pop, full, empty, lk_hit;
  logic [PW:0]      count;
  logic [31:0]      lk_data;
  wbuf_entry_t      push_entry, head_entry;
  logic             unused_addr;

  assign idx         = bus.addr[IDX_W+1:2];
  assign unused_addr = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};

  // Full buffer stalls even if a drain frees a slot this cycle; loads block drains.
  always_comb begin
    push       = bus.memwrite & ~full;
    pop        = ~bus.memread & ~empty;
    push_entry = '{idx: idx, data: bus.writedata};
  end

  dmem_wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .lk_idx     (idx),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
  );

  always_ff @(posedge clk) begin
    if (pop) array_q[head_entry.idx] <= head_entry.data;
  end

  assign bus.readdata   = lk_hit ? lk_data : array_q[idx];
  assign bus.stall      = bus.memwrite & full;
  assign bus.wbuf_count = CNT_W'(count);
  assign bus.wbuf_empty = empty;

  a_rw_exclusive : assert property (@(posedge clk) disable iff (!reset)
    !(bus.memread && bus.memwrite))
    else $warning("%s", MSG_RW_BOTH);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder; a scoreboard queue holds expected responses.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    logic        stall;
    int          cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb [$];

  dmem_responder_if bus ();

  dmem_responder #(.MEM_WORDS(256), .WBUF_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit chk_rd, input logic [31:0] erd, input bit estall,
                      input int ecnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus.memread   = rd;
    bus.memwrite  = wr;
    bus.addr      = a;
    bus.writedata = d;
    if (rd || wr) begin
      e.name   = nm;
      e.chk_rd = chk_rd;
      e.rd     = erd;
      e.stall  = estall;
      e.cnt    = ecnt;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0, "idle");
  endtask

  // Monitor: every active cycle presents a response that must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (bus.memread || bus.memwrite)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: got active cycle expected none queued");
      end else begin
        e = sb.pop_front();
        if (e.chk_rd) check({e.name, "_rd"}, bus.readdata, e.rd);
        check({e.name, "_stall"}, 32'(bus.stall), 32'(e.stall));
        check({e.name, "_cnt"}, 32'(bus.wbuf_count), 32'(e.cnt));
        check({e.name, "_empty"}, 32'(bus.wbuf_empty), 32'(e.cnt == 0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.addr      = 32'h0;
    bus.writedata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cnt", 32'(bus.wbuf_count), 32'd0);
    check("rst_empty", 32'(bus.wbuf_empty), 32'd1);
    check("rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Store then forwarded load, then load from the array after the drain
    step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 0, "t1_st");
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1, "t1_fwd");
    idle(1);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0, "t1_arr");

    // Youngest match among three entries to the same word
    step(1'b1, 1'b1, 32'h20, 32'h1, 1'b0, 32'h0, 1'b0, 0, "t2_w1");
    step(1'b1, 1'b1, 32'h20, 32'h2, 1'b1, 32'h1, 1'b0, 1, "t2_w2");
    step(1'b1, 1'b1, 32'h20, 32'h3, 1'b1, 32'h2, 1'b0, 2, "t2_w3");
    step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h3, 1'b0, 3, "t2_young");
    idle(3);
    step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h3, 1'b0, 0, "t2_arr");

    // Fill, one-cycle stall, accept, in-order commit
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 32'(32'h80 + 4*i), 32'(32'h100 + i), 1'b0, 32'h0, 1'b0, i, "t3_fill");
    step(1'b0, 1'b1, 32'h90, 32'h104, 1'b0, 32'h0, 1'b1, 4, "t3_stall");
    step(1'b0, 1'b1, 32'h90, 32'h104, 1'b0, 32'h0, 1'b0, 3, "t3_accept");
    idle(3);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 32'(32'h80 + 4*i), 32'h0, 1'b1, 32'(32'h100 + i), 1'b0, 0, "t3_commit");

    // Pointer wrap-around with store/load interleavings
    for (int i = 0; i < 10; i++) begin
      a = 32'(32'hC0 + 4*(i % 3));
      step(1'b0, 1'b1, a, 32'(32'h5000 + i), 1'b0, 32'h0, 1'b0, (i == 0) ? 0 : 1, "t4_st");
      step(1'b1, 1'b0, a, 32'h0, 1'b1, 32'(32'h5000 + i), 1'b0, 1, "t4_ld");
    end
    idle(2);
    @(negedge clk);
    check("t4_empty", 32'(bus.wbuf_empty), 32'd1);
    step(1'b1, 1'b0, 32'hC0, 32'h0, 1'b1, 32'h5009, 1'b0, 0, "t4_arr0");
    step(1'b1, 1'b0, 32'hC4, 32'h0, 1'b1, 32'h5007, 1'b0, 0, "t4_arr1");
    step(1'b1, 1'b0, 32'hC8, 32'h0, 1'b1, 32'h5008, 1'b0, 0, "t4_arr2");

    // Reset discards buffered stores
    step(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 0, "t5_z0");
    step(1'b0, 1'b1, 32'h44, 32'h0, 1'b0, 32'h0, 1'b0, 1, "t5_z1");
    step(1'b0, 1'b1, 32'h48, 32'h0, 1'b0, 32'h0, 1'b0, 1, "t5_z2");
    idle(2);
    step(1'b1, 1'b1, 32'h40, 32'h11, 1'b1, 32'h0, 1'b0, 0, "t5_b0");
    step(1'b1, 1'b1, 32'h44, 32'h22, 1'b1, 32'h0, 1'b0, 1, "t5_b1");
    step(1'b1, 1'b1, 32'h48, 32'h33, 1'b1, 32'h0, 1'b0, 2, "t5_b2");
    @(posedge clk);
    #1;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    reset        = 1'b0;
    #2;
    check("t5_rst_cnt", 32'(bus.wbuf_count), 32'd0);
    check("t5_rst_empty", 32'(bus.wbuf_empty), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, 0, "t5_ld0");
    step(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'h0, 1'b0, 0, "t5_ld1");
    step(1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 32'h0, 1'b0, 0, "t5_ld2");
    step(1'b0, 1'b1, 32'h4C, 32'h44, 1'b0, 32'h0, 1'b0, 0, "t5_st");
    idle(1);

    // Simultaneous read and write: store accepted, drain suppressed
    step(1'b1, 1'b1, 32'h10, 32'h99, 1'b1, 32'hDEADBEEF, 1'b0, 0, "t6_rw1");
    step(1'b1, 1'b1, 32'h10, 32'hAA, 1'b1, 32'h99, 1'b0, 1, "t6_rw2");
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hAA, 1'b0, 2, "t6_nodrain");
    idle(2);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hAA, 1'b0, 0, "t6_arr");
    idle(1);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core's M-stage port: it is the memory end of the memwriteM/aluoutM/writedataM/readdataM interface.
- Stores are posted into a small write buffer and return immediately. The buffer drains into a single-port word array on cycles with no load.
- Loads return combinationally in the same cycle, with store-to-load forwarding from the buffer.
- Raises stall to the core's hazard unit when the buffer cannot accept a store.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the backing array (power of 2).
- WBUF_DEPTH, 4, write-buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memread  in  1  M-stage load this cycle.
- memwrite  in  1  M-stage store this cycle.
- addr  in  32  byte address (aluoutM); bits [1:0] ignored; word index = addr[log2(MEM_WORDS)+1:2]; upper bits ignored.
- writedata  in  32  store data (writedataM).
- readdata  out  32  load data (readdataM), combinational.
- stall  out  1  store not accepted this cycle; core holds M stage.
- wbuf_count  out  log2(WBUF_DEPTH)+1  occupied entries.
- wbuf_empty  out  1  wbuf_count==0; used for halt/fence.

Behaviour:
- Reset (reset==0, async):
  - head, tail and count go to 0; wbuf_empty=1.
  - Pending buffered stores are discarded and never committed.
  - The array is not cleared.
  - stall is combinational and therefore 0 while memwrite=0.
- Write buffer is a circular FIFO of {word index, data}; head = oldest entry, tail = next free slot; pointers wrap modulo WBUF_DEPTH.
- Accept: when memwrite=1 and count<WBUF_DEPTH, push at the rising edge. The store returns with zero-cycle latency and stall=0.
- Full: stall = memwrite & (count==WBUF_DEPTH), with no bypass even if a drain occurs in the same cycle. Nothing is pushed; the drain frees a slot, so the held store is accepted on the next cycle (one-cycle stall).
- Drain: when memread=0 and count>0, write the head entry to the array at the rising edge and advance head. This gives at most one drain per cycle.
- Loads have priority over drains; a load cycle blocks the drain.
- Simultaneous push and drain: count unchanged, both pointers advance.
- Load data: readdata is the data of the youngest buffer entry whose index matches addr; if no entry matches, it is array[index].
  - An entry being drained in the current cycle is still forwarded.
  - Matching scans from tail-1 back to head, taking wrap-around into account.
- readdata is driven whenever memread=0 as well, using the same function. The core ignores it in that case.
- memread=1 and memwrite=1 in the same cycle is a protocol violation. An assertion fires; the write is treated as in the accept/full rules and the drain is suppressed.
- Repeated stores to the same index occupy separate entries; commit order is preserved, so the last write wins in the array.
- No byte enables; all accesses are full words.

Decomposition:
- Package dmem_pkg:
  - typedef wbuf_entry_t {logic [IDX_W-1:0] idx; logic [31:0] data;}
  - IDX_W and PTR_W localparams derived from the defaults.
  - Assertion message constants.
- Sub-module dmem_wbuf_fifo: circular FIFO with push/pop, count, full/empty, plus a combinational youngest-match lookup port (idx in; hit and data out).
- The top level holds the array, the drain/priority logic, the readdata mux and stall.

Test Plan:
- Store/load with forwarding: reset; store 0xDEADBEEF to addr 0x10; next cycle load 0x10 with memread held high → readdata=0xDEADBEEF from the buffer, wbuf_count=1; drop memread → count 0 next cycle; reload → 0xDEADBEEF from the array.
- Youngest match: stores 0x1, 0x2, 0x3 to addr 0x20 on consecutive cycles with memread=1 between them to block drains → load 0x20 returns 0x3; after a full drain, array[8]=0x3.
- Full stall: hold memread=1 while issuing WBUF_DEPTH stores, then a 5th store → stall=1 for exactly one cycle after memread drops; the 5th store is accepted next cycle; all 5 values commit in order.
- Wrap-around: 10 store/load interleavings forcing head and tail past index WBUF_DEPTH-1 → every load returns its last-stored value; wbuf_empty=1 at the end.
- Reset mid-operation: 3 buffered stores to 0x40/0x44/0x48 (array previously 0) → assert reset for one cycle, then load each → readdata=0, wbuf_count=0, stall=0.
- Protocol check: memread=memwrite=1 → assertion fires; no drain occurs that cycle.
